pantalla_frame_decoder: RTL
===========================

PANTALLA_FRAME_DECODER -- requirements
Module: pantalla_frame_decoder

Purpose: stage directly downstream of the UART receiver. It consumes received bytes, parses 4-byte command frames, and updates the display register file that drives the board LEDs.

Interface
REQ-001 Parameter TIMEOUT_CYC, default 43400, sets the inter-byte timeout in clkM cycles (10 byte times at 434 clk/bit).
REQ-002 Parameter NREG, default 8, sets the number of display registers.
REQ-003 clkM  input  1  single system clock; all logic is on the rising edge.
REQ-004 rstM  input  1  reset, asynchronous and active-low.
REQ-005 rx_data  input  8  byte from the UART receiver; valid only while rx_valid=1.
REQ-006 rx_valid  input  1  one-cycle strobe marking a new rx_data byte.
REQ-007 rd_addr  input  3  register read address.
REQ-008 rd_data  output  8  contents of reg[rd_addr]; combinational read.
REQ-009 leds  output  8  contents of reg[0], driven directly from the register.
REQ-010 frame_ok  output  1  one-cycle pulse marking a frame accepted.
REQ-011 frame_err  output  1  one-cycle pulse marking a frame rejected or timed out.
REQ-012 err_cnt  output  8  count of rejected frames; saturates at 255.

Function
REQ-013 Frame format SHALL be SYNC=0xAA, ADDR, DATA, CHK, with CHK=(ADDR+DATA) mod 256.
REQ-014 The state machine SHALL have four states: IDLE, GET_ADDR, GET_DATA, GET_CHK. It advances only on cycles with rx_valid=1.
REQ-015 IDLE: byte 0xAA -> GET_ADDR; any other byte SHALL be discarded silently, with no error and no count.
REQ-016 GET_ADDR latches the byte -> GET_DATA; GET_DATA latches the byte -> GET_CHK. In both states 0xAA is ordinary data; there is no escaping or resync.
REQ-017 GET_CHK -> IDLE always. The frame is accepted only if CHK matches and ADDR[7:3]==0; otherwise it is rejected.
REQ-018 On accept, reg[ADDR[2:0]] SHALL be written with DATA on the clock edge that samples CHK, and frame_ok SHALL be high for the following cycle only.
REQ-019 On reject, the register file SHALL be unchanged, frame_err SHALL pulse for one cycle, and err_cnt SHALL increment (saturating at 255).
REQ-020 The timeout counter SHALL clear on every rx_valid and count only in non-IDLE states.
REQ-021 When the timeout counter reaches TIMEOUT_CYC-1: state -> IDLE, the partial frame is dropped, frame_err pulses, and err_cnt increments.
REQ-022 If rx_valid and the timeout terminal count occur in the same cycle, the byte SHALL win: it is processed normally and no timeout fires.
REQ-023 frame_ok and frame_err SHALL never be asserted in the same cycle.
REQ-024 rd_data and leds SHALL reflect a write in the cycle after the write edge.
REQ-025 A new SYNC byte arriving the cycle after a CHK byte SHALL be accepted; no dead cycles are allowed between frames.

Reset
REQ-026 rstM low SHALL immediately force: state=IDLE, all registers=0x00, leds=0x00, err_cnt=0, timeout counter=0, frame_ok=0, frame_err=0.
REQ-027 Reset asserted mid-frame SHALL drop the partial frame without a frame_err pulse.
REQ-028 rx_valid in the first cycle after reset release SHALL be processed normally.

Structure
REQ-029 Package pantalla_pkg SHALL hold SYNC_BYTE=8'hAA, the state enumeration, and the NREG and TIMEOUT_CYC defaults.
REQ-030 Sub-module pantalla_regfile SHALL implement the NREG x 8 register file: one write port, one combinational read port, and a dedicated reg[0] output feeding leds.
REQ-031 Parsing, checksum, timeout and the error counter SHALL live in pantalla_frame_decoder itself.

Verification
REQ-032 Accept: AA 00 5A 5A -> leds=0x5A, one frame_ok pulse, err_cnt=0.
REQ-033 Addressed write: AA 03 10 13, then rd_addr=3 -> rd_data=0x10, leds unchanged. Then 55 13 AA 01 FF 00 -> the leading 55 and 13 are ignored and reg1=0xFF (0x01+0xFF=0x00).
REQ-034 Reject on checksum: AA 01 22 00 -> frame_err pulse, err_cnt=1, reg1 unchanged. Reject on address: AA 09 01 0A -> err_cnt=2, no register written.
REQ-035 Timeout: AA 02, then no rx_valid for 43400 cycles -> frame_err, state IDLE. The next frame AA 02 07 09 is then accepted with reg2=0x07. Separately, a byte landing on the terminal-count cycle produces no timeout.
REQ-036 Reset and saturation: rstM pulsed low after AA 04 -> no frame_err and all outputs 0. Then 300 bad frames -> err_cnt=255 and holds.

Source files
------------

// File: rtl/pantalla_pkg.sv
// pantalla_pkg: shared constants and parser state encoding for the frame decoder
package pantalla_pkg;
  localparam logic [7:0] SYNC_BYTE       = 8'hAA;
  localparam int         NREG_DEF        = 8;
  localparam int         TIMEOUT_CYC_DEF = 43400;
  typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, GET_CHK} state_e;
endpackage

// File: rtl/pantalla_regfile.sv
// pantalla_regfile: NREG x 8 display registers, one write port, combinational read, reg0 tap for leds
module pantalla_regfile import pantalla_pkg::*; #(
  parameter int NREG = NREG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr,
  output logic [7:0] rdata,
  output logic [7:0] reg0
);
  logic [7:0] regs_q [NREG];
  logic [7:0] regs_d [NREG];
  // next register contents: only the addressed entry changes on a write
  always_comb begin
    regs_d = regs_q;
    if (we && int'(waddr) < NREG) regs_d[waddr] = wdata;
  end
  // register storage, cleared by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  assign rdata = int'(raddr) < NREG ? regs_q[raddr] : '0;
  assign reg0  = regs_q[0];
endmodule

// File: rtl/pantalla_frame_decoder.sv
// pantalla_frame_decoder: parses AA/ADDR/DATA/CHK frames from the UART and writes the display registers
module pantalla_frame_decoder import pantalla_pkg::*; #(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int NREG        = NREG_DEF
) (
  input  logic       clkM,
  input  logic       rstM,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] leds,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d, err_cnt_q, err_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic          we, timeout, chk_ok;
  // parser next state: a received byte always takes priority over the timeout
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    we          = 1'b0;
    timeout     = state_q != IDLE && !rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1);
    chk_ok      = rx_data == 8'(addr_q + data_q) && addr_q[7:3] == 5'd0;
    if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        IDLE:     state_d = rx_data == SYNC_BYTE ? GET_ADDR : IDLE;
        GET_ADDR: begin addr_d = rx_data; state_d = GET_DATA; end
        GET_DATA: begin data_d = rx_data; state_d = GET_CHK; end
        default:  begin state_d = IDLE; we = chk_ok; frame_ok_d = chk_ok; frame_err_d = !chk_ok; end
      endcase
    end else if (timeout) begin
      state_d     = IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end else if (state_q != IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end
    err_cnt_d = frame_err_d && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  // parser state, frame fields, timeout counter and registered status outputs
  always_ff @(posedge clkM or negedge rstM)
    if (!rstM) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      err_cnt_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      err_cnt_q   <= err_cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
    end
  pantalla_regfile #(.NREG(NREG)) u_regfile (
    .clk   (clkM),
    .rst_n (rstM),
    .we    (we),
    .waddr (addr_q[2:0]),
    .wdata (data_q),
    .raddr (rd_addr),
    .rdata (rd_data),
    .reg0  (leds)
  );
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
endmodule
